// File: rtl/rv_ctl_fsm.sv
// rv_ctl_fsm: multicycle RV32I control FSM; ports clk/rst, instr/zero/dmem_ready in, datapath strobes, illegal/bus_err/halted out
module rv_ctl_fsm #(
  parameter int DPWIDTH = 32,
  parameter int DMEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DPWIDTH-1:0] instr,
  input  logic               zero,
  input  logic               dmem_ready,
  output logic               pcsourse,
  output logic               pcwrite,
  output logic               pccen,
  output logic               irwrite,
  output logic [1:0]         wbsel,
  output logic               regwen,
  output logic [1:0]         immsel,
  output logic [1:0]         asel,
  output logic               bsel,
  output logic [3:0]         alusel,
  output logic               mdrwrite,
  output logic               select_output,
  output logic               dmem_wen,
  output logic               illegal,
  output logic               bus_err,
  output logic               halted
);
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, HALT
  } state_t;
  state_t state, nxt;
  logic [7:0] cnt;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [3:0] alu_base;
  logic r_ill, i_ill, tmo, unused;
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[31:25];
  assign unused = ^{instr[24:15], instr[11:7]};
  // f3 -> ADD0 SLL2 SLT3 SLTU4 XOR5 SRL6 OR8 AND9; SUB/SRA are base+1
  assign alu_base = 4'(f3) + 4'(f3 != 3'd0) + 4'(&f3[2:1]);
  assign r_ill = !(f7 == 7'b0000000 || f7 == 7'b0100000) || (f7[5] && f3 != 3'd0 && f3 != 3'd5);
  assign i_ill = (f3 == 3'd1 || f3 == 3'd5) && f7 != 7'd0;
  // last allowed wait cycle; ready here still completes
  assign tmo = cnt == 8'(DMEM_TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      cnt <= '0;
    end else begin
      state <= nxt;
      cnt <= state == MEM_ADDR ? 8'd0 :
             ((state == MEM_RD || state == MEM_WR) && !dmem_ready) ? cnt + 8'd1 : cnt;
    end
  end
  always_comb begin
    nxt = state;
    pcsourse = 1'b0;
    pcwrite = 1'b0;
    pccen = 1'b0;
    irwrite = 1'b0;
    wbsel = 2'd0;
    regwen = 1'b0;
    immsel = 2'd0;
    asel = 2'd0;
    bsel = 1'b0;
    alusel = 4'd0;
    mdrwrite = 1'b0;
    select_output = 1'b0;
    dmem_wen = 1'b0;
    illegal = 1'b0;
    bus_err = 1'b0;
    halted = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          irwrite = 1'b1;
          pccen = 1'b1;
          pcwrite = 1'b1;
          nxt = DECODE;
        end
        DECODE: begin
          asel = 2'd1;
          bsel = 1'b1;
          immsel = opc == 7'b1101111 ? 2'd0 : 2'd1;
          nxt = FETCH;
          case (opc)
            7'b0110011: nxt = EXEC_R;
            7'b0010011: nxt = EXEC_I;
            7'b0000011, 7'b0100011: nxt = f3 == 3'b010 ? MEM_ADDR : FETCH;
            7'b1100011: nxt = f3[2:1] == 2'b00 ? BRANCH : FETCH;
            7'b1101111: nxt = JAL;
            7'b1110011: nxt = HALT;
            default: nxt = FETCH;
          endcase
          illegal = nxt == FETCH;
        end
        EXEC_R: begin
          illegal = r_ill;
          alusel = r_ill ? 4'd0 : alu_base + 4'(f7[5]);
          nxt = r_ill ? FETCH : ALU_WB;
        end
        EXEC_I: begin
          illegal = i_ill;
          bsel = !i_ill;
          immsel = i_ill ? 2'd0 : 2'd3;
          alusel = i_ill ? 4'd0 : alu_base;
          nxt = i_ill ? FETCH : ALU_WB;
        end
        ALU_WB: begin
          regwen = 1'b1;
          wbsel = 2'd1;
          nxt = FETCH;
        end
        MEM_ADDR: begin
          bsel = 1'b1;
          immsel = opc[5] ? 2'd2 : 2'd3;
          nxt = opc[5] ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          bsel = 1'b1;
          immsel = 2'd3;
          mdrwrite = dmem_ready;
          bus_err = !dmem_ready && tmo;
          nxt = dmem_ready ? MEM_WB : tmo ? FETCH : MEM_RD;
        end
        MEM_WB: begin
          regwen = 1'b1;
          nxt = FETCH;
        end
        MEM_WR: begin
          bsel = 1'b1;
          immsel = 2'd2;
          select_output = 1'b1;
          dmem_wen = 1'b1;
          bus_err = !dmem_ready && tmo;
          nxt = (dmem_ready || tmo) ? FETCH : MEM_WR;
        end
        BRANCH: begin
          alusel = 4'd1;
          pcwrite = f3[0] ? !zero : zero;
          pcsourse = pcwrite;
          nxt = FETCH;
        end
        JAL: begin
          regwen = 1'b1;
          wbsel = 2'd2;
          pcwrite = 1'b1;
          pcsourse = 1'b1;
          nxt = FETCH;
        end
        HALT: halted = 1'b1;
        default: nxt = FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_ctl_fsm.sv
// tb_rv_ctl_fsm: vector-table and scoreboard bench for rv_ctl_fsm
module tb_rv_ctl_fsm;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, dmem_ready = 1'b0;
  logic [31:0] instr = '0;
  logic pcsourse, pcwrite, pccen, irwrite, regwen, bsel, mdrwrite, select_output, dmem_wen, illegal, bus_err, halted;
  logic [1:0] wbsel, immsel, asel;
  logic [3:0] alusel;
  int tests = 0, fails = 0;

  rv_ctl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .dmem_ready(dmem_ready),
    .pcsourse(pcsourse), .pcwrite(pcwrite), .pccen(pccen), .irwrite(irwrite), .wbsel(wbsel),
    .regwen(regwen), .immsel(immsel), .asel(asel), .bsel(bsel), .alusel(alusel),
    .mdrwrite(mdrwrite), .select_output(select_output), .dmem_wen(dmem_wen),
    .illegal(illegal), .bus_err(bus_err), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {logic r; logic [31:0] i; logic z; logic rd; logic [21:0] e; string n;} vec_t;
  typedef struct {logic [21:0] e; string n;} sb_t;
  vec_t tbl[$];
  sb_t sb[$];

  function automatic logic [21:0] mk(input logic pcs, pcw, pcc, irw, input logic [1:0] wb, input logic rw,
                                     input logic [1:0] im, as, input logic bs, input logic [3:0] al,
                                     input logic mdr, so, wen, ill, be, h);
    return {pcs, pcw, pcc, irw, wb, rw, im, as, bs, al, mdr, so, wen, ill, be, h};
  endfunction

  logic [21:0] act;
  assign act = {pcsourse, pcwrite, pccen, irwrite, wbsel, regwen, immsel, asel, bsel, alusel,
                mdrwrite, select_output, dmem_wen, illegal, bus_err, halted};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t s;
      s = sb.pop_front();
      tests++;
      if (act !== s.e) begin
        fails++;
        $display("FAIL %s: got %h expected %h", s.n, act, s.e);
      end
    end
  end

  task automatic step(input logic r, input logic [31:0] i, input logic z, input logic rd,
                      input logic [21:0] e, input string n);
    sb_t s;
    @(posedge clk);
    #1;
    rst = r;
    instr = i;
    zero = z;
    dmem_ready = rd;
    s.e = e;
    s.n = n;
    sb.push_back(s);
  endtask

  task automatic add(input logic r, input logic [31:0] i, input logic z, input logic rd,
                     input logic [21:0] e, input string n);
    vec_t v;
    v.r = r; v.i = i; v.z = z; v.rd = rd; v.e = e; v.n = n;
    tbl.push_back(v);
  endtask

  logic [21:0] Z, F, DJ, DB, AWB, MAL, MAS, MWB, J, ILL, H, BE;

  function automatic logic [21:0] er(input logic [3:0] al);
    return mk(0,0,0,0,2'd0,0,2'd0,2'd0,0,al,0,0,0,0,0,0);
  endfunction
  function automatic logic [21:0] ei(input logic [3:0] al);
    return mk(0,0,0,0,2'd0,0,2'd3,2'd0,1,al,0,0,0,0,0,0);
  endfunction
  function automatic logic [21:0] br(input logic t);
    return mk(t,t,0,0,2'd0,0,2'd0,2'd0,0,4'd1,0,0,0,0,0,0);
  endfunction
  function automatic logic [21:0] mwr(input logic be);
    return mk(0,0,0,0,2'd0,0,2'd2,2'd0,1,4'd0,0,1,1,0,be,0);
  endfunction
  function automatic logic [21:0] mrd(input logic mdr, input logic be);
    return mk(0,0,0,0,2'd0,0,2'd3,2'd0,1,4'd0,mdr,0,0,0,be,0);
  endfunction

  initial begin
    logic [31:0] ADD_I, SUB_I, SRA_I, RBAD, ADDI, ORI, SRAI, SLLIB, BAD7F, LW, SW, BEQ, BNE, BLT, JALI, ECALL;
    ADD_I = 32'h002081B3; SUB_I = 32'h402081B3; SRA_I = 32'h4020D1B3; RBAD = 32'h402091B3;
    ADDI = 32'h00500093; ORI = 32'h00006093; SRAI = 32'h4010D093; SLLIB = 32'h02001093;
    BAD7F = 32'h0000007F; LW = 32'h0080A283; SW = 32'h0020A023; BEQ = 32'h00000063;
    BNE = 32'h00001063; BLT = 32'h00004063; JALI = 32'h0000006F; ECALL = 32'h00000073;
    Z   = '0;
    F   = mk(0,1,1,1,2'd0,0,2'd0,2'd0,0,4'd0,0,0,0,0,0,0);
    DJ  = mk(0,0,0,0,2'd0,0,2'd0,2'd1,1,4'd0,0,0,0,0,0,0);
    DB  = mk(0,0,0,0,2'd0,0,2'd1,2'd1,1,4'd0,0,0,0,0,0,0);
    AWB = mk(0,0,0,0,2'd1,1,2'd0,2'd0,0,4'd0,0,0,0,0,0,0);
    MAL = mk(0,0,0,0,2'd0,0,2'd3,2'd0,1,4'd0,0,0,0,0,0,0);
    MAS = mk(0,0,0,0,2'd0,0,2'd2,2'd0,1,4'd0,0,0,0,0,0,0);
    MWB = mk(0,0,0,0,2'd0,1,2'd0,2'd0,0,4'd0,0,0,0,0,0,0);
    J   = mk(1,1,0,0,2'd2,1,2'd0,2'd0,0,4'd0,0,0,0,0,0,0);
    ILL = mk(0,0,0,0,2'd0,0,2'd0,2'd0,0,4'd0,0,0,0,1,0,0);
    H   = mk(0,0,0,0,2'd0,0,2'd0,2'd0,0,4'd0,0,0,0,0,0,1);
    BE  = mk(0,0,0,0,2'd0,0,2'd0,2'd0,0,4'd0,0,0,0,0,1,0);

    @(negedge clk);
    tests++;
    if (act !== Z) begin
      fails++;
      $display("FAIL reset_state: got %h expected %h", act, Z);
    end

    add(1, ADD_I, 0, 0, Z, "reset");
    add(0, ADD_I, 0, 0, F, "add_fetch"); add(0, ADD_I, 0, 0, DB, "add_decode");
    add(0, ADD_I, 0, 0, er(4'd0), "add_exec"); add(0, ADD_I, 0, 0, AWB, "add_wb");
    add(0, SUB_I, 0, 0, F, "sub_fetch"); add(0, SUB_I, 0, 0, DB, "sub_decode");
    add(0, SUB_I, 0, 0, er(4'd1), "sub_exec"); add(0, SUB_I, 0, 0, AWB, "sub_wb");
    add(0, SRA_I, 0, 0, F, "sra_fetch"); add(0, SRA_I, 0, 0, DB, "sra_decode");
    add(0, SRA_I, 0, 0, er(4'd7), "sra_exec"); add(0, SRA_I, 0, 0, AWB, "sra_wb");
    add(0, RBAD, 0, 0, F, "rbad_fetch"); add(0, RBAD, 0, 0, DB, "rbad_decode");
    add(0, RBAD, 0, 0, ILL, "rbad_illegal");
    add(0, ADDI, 0, 0, F, "addi_fetch"); add(0, ADDI, 0, 0, DB, "addi_decode");
    add(0, ADDI, 0, 0, ei(4'd0), "addi_exec"); add(0, ADDI, 0, 0, AWB, "addi_wb");
    add(0, ORI, 0, 0, F, "ori_fetch"); add(0, ORI, 0, 0, DB, "ori_decode");
    add(0, ORI, 0, 0, ei(4'd8), "ori_exec"); add(0, ORI, 0, 0, AWB, "ori_wb");
    add(0, SRAI, 0, 0, F, "srai_fetch"); add(0, SRAI, 0, 0, DB, "srai_decode");
    add(0, SRAI, 0, 0, ILL, "srai_illegal");
    add(0, SLLIB, 0, 0, F, "slli_fetch"); add(0, SLLIB, 0, 0, DB, "slli_decode");
    add(0, SLLIB, 0, 0, ILL, "slli_illegal");
    add(0, BAD7F, 0, 0, F, "op7f_fetch"); add(0, BAD7F, 0, 0, DB | ILL, "op7f_illegal");
    add(0, LW, 0, 0, F, "lw_fetch"); add(0, LW, 0, 0, DB, "lw_decode");
    add(0, LW, 0, 0, MAL, "lw_addr"); add(0, LW, 0, 0, mrd(0, 0), "lw_wait1");
    add(0, LW, 0, 0, mrd(0, 0), "lw_wait2"); add(0, LW, 0, 1, mrd(1, 0), "lw_ready");
    add(0, LW, 0, 0, MWB, "lw_wb");
    add(0, SW, 0, 0, F, "sw_fetch"); add(0, SW, 0, 0, DB, "sw_decode");
    add(0, SW, 0, 0, MAS, "sw_addr"); add(0, SW, 0, 1, mwr(0), "sw_ready");
    add(0, BEQ, 1, 0, F, "beq1_fetch"); add(0, BEQ, 1, 0, DB, "beq1_decode");
    add(0, BEQ, 1, 0, br(1), "beq_taken");
    add(0, BEQ, 0, 0, F, "beq0_fetch"); add(0, BEQ, 0, 0, DB, "beq0_decode");
    add(0, BEQ, 0, 0, br(0), "beq_not_taken");
    add(0, BNE, 0, 0, F, "bne0_fetch"); add(0, BNE, 0, 0, DB, "bne0_decode");
    add(0, BNE, 0, 0, br(1), "bne_taken");
    add(0, BNE, 1, 0, F, "bne1_fetch"); add(0, BNE, 1, 0, DB, "bne1_decode");
    add(0, BNE, 1, 0, br(0), "bne_not_taken");
    add(0, BLT, 0, 0, F, "blt_fetch"); add(0, BLT, 0, 0, DB | ILL, "blt_illegal");
    add(0, JALI, 0, 0, F, "jal_fetch"); add(0, JALI, 0, 0, DJ, "jal_decode");
    add(0, JALI, 0, 0, J, "jal_exec");

    foreach (tbl[k]) step(tbl[k].r, tbl[k].i, tbl[k].z, tbl[k].rd, tbl[k].e, tbl[k].n);

    step(0, SW, 0, 0, F, "swto_fetch"); step(0, SW, 0, 0, DB, "swto_decode");
    step(0, SW, 0, 0, MAS, "swto_addr");
    for (int k = 0; k < 14; k++) step(0, SW, 0, 0, mwr(0), "swto_wait");
    step(0, SW, 0, 0, mwr(1), "swto_bus_err");
    @(negedge clk);
    tests++;
    if (bus_err !== 1'b1) begin
      fails++;
      $display("FAIL swto_expired: bus_err=%b expected 1", bus_err);
    end

    step(0, LW, 0, 0, F, "lwedge_fetch"); step(0, LW, 0, 0, DB, "lwedge_decode");
    step(0, LW, 0, 0, MAL, "lwedge_addr");
    for (int k = 0; k < 14; k++) step(0, LW, 0, 0, mrd(0, 0), "lwedge_wait");
    step(0, LW, 0, 1, mrd(1, 0), "lwedge_last_ready");
    step(0, LW, 0, 0, MWB, "lwedge_wb");

    step(0, LW, 0, 0, F, "lwto_fetch"); step(0, LW, 0, 0, DB, "lwto_decode");
    step(0, LW, 0, 0, MAL, "lwto_addr");
    for (int k = 0; k < 14; k++) step(0, LW, 0, 0, mrd(0, 0), "lwto_wait");
    step(0, LW, 0, 0, mrd(0, 1), "lwto_bus_err");

    step(0, LW, 0, 0, F, "lwrst_fetch"); step(0, LW, 0, 0, DB, "lwrst_decode");
    step(0, LW, 0, 0, MAL, "lwrst_addr"); step(0, LW, 0, 0, mrd(0, 0), "lwrst_wait");
    step(1, LW, 0, 1, Z, "lwrst_in_reset");

    step(0, ECALL, 0, 0, F, "ecall_fetch"); step(0, ECALL, 0, 0, DB, "ecall_decode");
    for (int k = 0; k < 4; k++) step(0, ECALL, 0, 1, H, "ecall_halted");
    step(1, ECALL, 0, 0, Z, "halt_reset");
    step(0, ADD_I, 0, 0, F, "after_halt_fetch");

    @(negedge clk);
    #1;
    if (BE == Z) $display("unexpected constant");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
